// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//   Input side : in_valid / in_ready handshake carrying ctrl (opcode) and x, y.
//   Output side: out_valid / out_ready handshake carrying out and carry.
// Modports:
//   master - the producer/consumer environment around the ALU.
//   slave  - the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;

    modport master (
        output in_valid,
        output ctrl,
        output x,
        output y,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  carry
    );

    modport slave (
        input  in_valid,
        input  ctrl,
        input  x,
        input  y,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output carry
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with a multi-cycle shift-add multiplier.
//   clk  - rising-edge clock.
//   rst  - synchronous, active-high reset; aborts any operation in flight.
//   bus  - alu_seq_if.slave:
//            in_valid/in_ready/ctrl/x/y    operand port (accept = valid && ready)
//            out_valid/out_ready/out/carry result port, fully registered
// Single-cycle opcodes produce a result one cycle after accept. Opcode 1101
// runs WIDTH shift-add iterations before presenting its result. in_ready
// depends only on the FSM state and out_ready, so no path exists from the
// operand side to any output.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_ASR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_SLT = 4'b1110;

    // Iteration counter start value: WIDTH iterations, counting down to zero.
    localparam logic [SHW-1:0] CNT_LOAD = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_FULL = 2'b10
    } state_t;

    // Single-cycle opcode evaluation at WIDTH+1 bits; returns {carry, out}.
    // Operands are zero-extended so NOT/NOR naturally yield carry=1 and
    // subtraction yields a borrow in the top bit.
    function automatic logic [WIDTH:0] alu_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   ae;
        logic [WIDTH:0]   be;
        logic [WIDTH:0]   r;
        logic [SHW-1:0]   amt;
        ae  = {1'b0, a};
        be  = {1'b0, b};
        amt = a[SHW-1:0];
        r   = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD:  r = ae + be;
            OP_SUB:  r = ae - be;
            OP_AND:  r = ae & be;
            OP_OR:   r = ae | be;
            OP_NOT:  r = ~ae;
            OP_XOR:  r = ae ^ be;
            OP_NOR:  r = ~(ae | be);
            OP_SHL:  r = be << amt;
            OP_SHR:  r = {1'b0, b >> amt};
            OP_ASR:  r = {1'b0, a[WIDTH-1], a[WIDTH-1:1]};
            OP_ROL:  r = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  r = {1'b0, a[0], a[WIDTH-1:1]};
            OP_EQ:   r = {{WIDTH{1'b0}}, (a == b)};
            OP_SLT:  r = {{WIDTH{1'b0}}, ($signed(a) < $signed(b))};
            // Multiply is handled by the iterative datapath; 1111 is reserved.
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               is_mul_s;

    logic [WIDTH-1:0]   out_r;
    logic [WIDTH-1:0]   out_nx_s;
    logic               carry_r;
    logic               carry_nx_s;
    logic               out_valid_r;
    logic               out_valid_nx_s;

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nx_s;
    logic [2*WIDTH-1:0] acc_sum_s;
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] mcand_nx_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   mplier_nx_s;
    logic [SHW-1:0]     cnt_r;
    logic [SHW-1:0]     cnt_nx_s;

    assign is_mul_s = (bus.ctrl == OP_MUL);
    assign accept_s = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.carry     = carry_r;

    // FSM next-state and in_ready; in_ready never looks at in_valid.
    always_comb begin
        state_nx_s = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    if (is_mul_s) begin
                        state_nx_s = ST_MUL;
                    end else begin
                        state_nx_s = ST_FULL;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                in_ready_s = 1'b0;
                if (cnt_r == CNT_ZERO) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            ST_FULL: begin
                // A new operand may enter only in the cycle the result leaves.
                in_ready_s = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        if (is_mul_s) begin
                            state_nx_s = ST_MUL;
                        end else begin
                            state_nx_s = ST_FULL;
                        end
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: begin
                in_ready_s = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // One shift-add step: add the current shifted multiplicand when the
    // multiplier LSB is set.
    always_comb begin
        if (mplier_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
    end

    // Datapath next values: capture at accept, iterate in MUL, drop valid on take.
    always_comb begin
        out_nx_s       = out_r;
        carry_nx_s     = carry_r;
        out_valid_nx_s = out_valid_r;
        acc_nx_s       = acc_r;
        mcand_nx_s     = mcand_r;
        mplier_nx_s    = mplier_r;
        cnt_nx_s       = cnt_r;
        if (accept_s) begin
            if (is_mul_s) begin
                // The previous result (if any) leaves this cycle; nothing is
                // presented until the multiply completes.
                out_valid_nx_s = 1'b0;
                acc_nx_s       = {(2*WIDTH){1'b0}};
                mcand_nx_s     = {{WIDTH{1'b0}}, bus.x};
                mplier_nx_s    = bus.y;
                cnt_nx_s       = CNT_LOAD;
            end else begin
                {carry_nx_s, out_nx_s} = alu_op(bus.ctrl, bus.x, bus.y);
                out_valid_nx_s         = 1'b1;
            end
        end else if (state_r == ST_MUL) begin
            acc_nx_s    = acc_sum_s;
            mcand_nx_s  = mcand_r << 1'b1;
            mplier_nx_s = mplier_r >> 1'b1;
            if (cnt_r == CNT_ZERO) begin
                // Last iteration: low half is the result, any high bit is overflow.
                out_nx_s       = acc_sum_s[WIDTH-1:0];
                carry_nx_s     = |acc_sum_s[2*WIDTH-1:WIDTH];
                out_valid_nx_s = 1'b1;
                cnt_nx_s       = CNT_ZERO;
            end else begin
                cnt_nx_s       = cnt_r - CNT_ONE;
            end
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_nx_s = 1'b0;
        end else begin
            out_valid_nx_s = out_valid_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Result and multiplier registers; reset discards any result in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
            acc_r       <= {(2*WIDTH){1'b0}};
            mcand_r     <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            cnt_r       <= CNT_ZERO;
        end else begin
            out_r       <= out_nx_s;
            carry_r     <= carry_nx_s;
            out_valid_r <= out_valid_nx_s;
            acc_r       <= acc_nx_s;
            mcand_r     <= mcand_nx_s;
            mplier_r    <= mplier_nx_s;
            cnt_r       <= cnt_nx_s;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
// Results are predicted by an integer model at each accept and compared when
// the consumer takes them; directed steps additionally check latency,
// backpressure and reset behaviour against fixed values.
module tb_alu_seq;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] q8[$];
    logic [63:0] q16[$];
    int   cyc;
    int   lat;
    bit   busy;
    bit   stale;

    alu_seq_if #(.WIDTH(8))  b8 ();
    alu_seq_if #(.WIDTH(16)) b16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {carry, out} as a (w+1)-bit integer.
    function automatic logic [63:0] model(input int w, input logic [3:0] c,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, top, r, amt, p;
        longint      sa, sv;
        int          sb;
        m   = (64'd1 << w) - 64'd1;
        top = 64'd1 << w;
        sb  = 0;
        while ((1 << sb) < w) sb++;
        amt = a & ((64'd1 << sb) - 64'd1);
        case (c)
            4'd0:  r = a + b;
            4'd1:  r = (a - b) & (m | top);
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = (~a & m) | top;
            4'd5:  r = a ^ b;
            4'd6:  r = (~(a | b) & m) | top;
            4'd7:  r = (b << amt) & (m | top);
            4'd8:  r = b >> amt;
            4'd9:  r = (a >> 1) | (a & (top >> 1));
            4'd10: r = ((a << 1) | (a >> (w - 1))) & m;
            4'd11: r = (a >> 1) | ((a & 64'd1) << (w - 1));
            4'd12: r = (a == b) ? 64'd1 : 64'd0;
            4'd13: begin
                p = a * b;
                r = (p & m) | (((p >> w) != 64'd0) ? top : 64'd0);
            end
            4'd14: begin
                sa = ((a & (top >> 1)) != 64'd0) ? longint'(a - top) : longint'(a);
                sv = ((b & (top >> 1)) != 64'd0) ? longint'(b - top) : longint'(b);
                r  = (sa < sv) ? 64'd1 : 64'd0;
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Scoreboard: pop/compare on take, push prediction on accept, flush on reset.
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            q16.delete();
        end else begin
            if (b8.out_valid && b8.out_ready) begin
                check("sb8_pending", 64'(q8.size() > 0), 64'd1);
                if (q8.size() > 0) check("sb8_result", 64'({b8.carry, b8.out}), q8.pop_front());
            end
            if (b8.in_valid && b8.in_ready) q8.push_back(model(8, b8.ctrl, 64'(b8.x), 64'(b8.y)));
            if (b16.out_valid && b16.out_ready) begin
                check("sb16_pending", 64'(q16.size() > 0), 64'd1);
                if (q16.size() > 0) check("sb16_result", 64'({b16.carry, b16.out}), q16.pop_front());
            end
            if (b16.in_valid && b16.in_ready) q16.push_back(model(16, b16.ctrl, 64'(b16.x), 64'(b16.y)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and wait for its accept; scrambles operands afterwards.
    task automatic send8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] bb, output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        b8.in_valid = 1'b1; b8.ctrl = c; b8.x = a; b8.y = bb;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = b8.in_ready;
            tick();
            n++;
        end
        b8.in_valid = 1'b0;
        b8.ctrl = 4'($urandom); b8.x = 8'($urandom); b8.y = 8'($urandom);
        check("send8_accept", 64'(ok), 64'd1);
    endtask

    task automatic send16(input logic [3:0] c, input logic [15:0] a, input logic [15:0] bb, output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        b16.in_valid = 1'b1; b16.ctrl = c; b16.x = a; b16.y = bb;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = b16.in_ready;
            tick();
            n++;
        end
        b16.in_valid = 1'b0;
        b16.ctrl = 4'($urandom); b16.x = 16'($urandom); b16.y = 16'($urandom);
        check("send16_accept", 64'(ok), 64'd1);
    endtask

    // Multiply at WIDTH=8: latency, in_ready low while busy, and result.
    task automatic mul8(input logic [7:0] a, input logic [7:0] bb, input logic [63:0] exp, input string tag);
        int n, l;
        bit bz;
        send8(4'b1101, a, bb, n);
        l  = 0;
        bz = 1'b0;
        while (!b8.out_valid && l < 40) begin
            bz |= b8.in_ready;
            tick();
            l++;
        end
        check({tag, "_lat"}, 64'(l), 64'd8);
        check({tag, "_busy"}, 64'(bz), 64'd0);
        check({tag, "_res"}, 64'({b8.out_valid, b8.carry, b8.out}), exp);
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        b8.in_valid = 1'b0;  b8.ctrl = 4'd0;  b8.x = 8'd0;   b8.y = 8'd0;   b8.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.ctrl = 4'd0; b16.x = 16'd0; b16.y = 16'd0; b16.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out8", 64'({b8.out_valid, b8.carry, b8.out}), 64'd0);
        check("rst_out16", 64'({b16.out_valid, b16.carry, b16.out}), 64'd0);
        rst = 1'b0;
        check("rst_ready8", 64'(b8.in_ready), 64'd1);

        // Single-cycle ops, back to back; each visible the cycle after accept.
        send8(4'b0000, 8'hFF, 8'h01, cyc);
        check("add_ff_01", 64'({b8.out_valid, b8.carry, b8.out}), 64'h300);
        send8(4'b0001, 8'h03, 8'h05, cyc);
        check("sub_cyc", 64'(cyc), 64'd1);
        check("sub_03_05", 64'({b8.out_valid, b8.carry, b8.out}), 64'h3FE);
        send8(4'b0100, 8'h0F, 8'h00, cyc);
        check("not_0f", 64'({b8.out_valid, b8.carry, b8.out}), 64'h3F0);
        send8(4'b0111, 8'h0A, 8'hC1, cyc);
        check("shl_c1_2", 64'({b8.out_valid, b8.carry, b8.out}), 64'h304);
        send8(4'b1000, 8'hF9, 8'h80, cyc);
        check("shr_hi_ignored", 64'({b8.out_valid, b8.carry, b8.out}), 64'h240);
        tick();
        check("idle_after_take", 64'(b8.out_valid), 64'd0);

        // Multiply, including the boundary operands.
        mul8(8'd20, 8'd13, 64'h304, "mul_20x13");
        mul8(8'd15, 8'd17, 64'h2FF, "mul_15x17");
        mul8(8'hA5, 8'h01, 64'h2A5, "mul_y1");
        mul8(8'h00, 8'hC3, 64'h200, "mul_x0");

        // Back-to-back single-cycle ops straight after a multiply result.
        send8(4'b0010, 8'hF0, 8'h3C, cyc);
        check("and_val", 64'({b8.out_valid, b8.carry, b8.out}), 64'h230);
        send8(4'b0011, 8'hF0, 8'h3C, cyc);
        check("or_cyc", 64'(cyc), 64'd1);
        check("or_val", 64'({b8.out_valid, b8.carry, b8.out}), 64'h2FC);
        send8(4'b1010, 8'h81, 8'h00, cyc);
        check("rol_cyc", 64'(cyc), 64'd1);
        check("rol_val", 64'({b8.out_valid, b8.carry, b8.out}), 64'h203);
        send8(4'b1110, 8'h80, 8'h01, cyc);
        check("slt_cyc", 64'(cyc), 64'd1);
        check("slt_val", 64'({b8.out_valid, b8.carry, b8.out}), 64'h201);
        tick();

        // Backpressure: result held, pending op blocked, then follows next cycle.
        b8.out_ready = 1'b0;
        send8(4'b0000, 8'h10, 8'h20, cyc);
        b8.in_valid = 1'b1; b8.ctrl = 4'b0101; b8.x = 8'h0F; b8.y = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 64'({b8.out_valid, b8.carry, b8.out}), 64'h230);
            check("bp_ready", 64'(b8.in_ready), 64'd0);
            tick();
        end
        b8.out_ready = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        check("bp_next", 64'({b8.out_valid, b8.carry, b8.out}), 64'h2F0);
        tick();

        // Reset on the 4th multiply cycle discards the multiply.
        send8(4'b1101, 8'd7, 8'd9, cyc);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mul_out", 64'({b8.out_valid, b8.carry, b8.out}), 64'd0);
        check("rst_mul_ready", 64'(b8.in_ready), 64'd1);
        stale = 1'b0;
        repeat (12) begin
            stale |= b8.out_valid;
            tick();
        end
        check("no_stale", 64'(stale), 64'd0);

        // Random mix checked through the scoreboard, with occasional stalls.
        for (int i = 0; i < 40; i++) begin
            b8.out_ready = 1'b1;
            send8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), cyc);
            if ($urandom_range(0, 3) == 0) begin
                b8.out_ready = 1'b0;
                repeat (2) tick();
                b8.out_ready = 1'b1;
            end
        end
        b8.out_ready = 1'b1;
        repeat (20) tick();
        check("sb8_drained", 64'(q8.size()), 64'd0);

        // WIDTH=16: add carry out and 16-cycle multiply latency.
        send16(4'b0000, 16'hFFFF, 16'h0001, cyc);
        check("add16", 64'({b16.out_valid, b16.carry, b16.out}), 64'h30000);
        send16(4'b1101, 16'd300, 16'd250, cyc);
        lat  = 0;
        busy = 1'b0;
        while (!b16.out_valid && lat < 60) begin
            busy |= b16.in_ready;
            tick();
            lat++;
        end
        check("mul16_lat", 64'(lat), 64'd16);
        check("mul16_busy", 64'(busy), 64'd0);
        check("mul16_res", 64'({b16.out_valid, b16.carry, b16.out}), 64'h324F8);
        repeat (4) tick();
        check("sb16_drained", 64'(q16.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It carries the same 13 opcodes at WIDTH bits and adds signed compare and a multi-cycle shift-add multiply. Operands enter through a valid/ready port, and results leave from a registered valid/ready port, so the block can sit between pipeline stages without combinational paths from input to output.

## Interface
- WIDTH, 8, operand/result width; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount width (derived; not to be overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block accepts when in_valid && in_ready at a rising edge.
- ctrl  in  4  opcode.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- out  out  WIDTH  result.
- carry  out  1  carry/extra result bit.

## Operation
- Opcodes. Arithmetic is done at WIDTH+1 bits, and {carry,out} = the (WIDTH+1)-bit result unless stated otherwise.
  - 0000: x+y.
  - 0001: x−y; carry=1 on borrow (x<y unsigned).
  - 0010: x&y, carry=0.
  - 0011: x|y, carry=0.
  - 0100: ~x, zero-extended before inversion, so carry=1.
  - 0101: x^y, carry=0.
  - 0110: ~(x|y), zero-extended, so carry=1.
  - 0111: y << x[SHW-1:0] at WIDTH+1 bits; carry = bit WIDTH of the shifted value.
  - 1000: y >> x[SHW-1:0], carry=0.
  - 1001: arithmetic shift right by 1 of x.
  - 1010: rotate x left by 1.
  - 1011: rotate x right by 1.
  - 1100: out={0…,x==y}.
  - 1110: out={0…,$signed(x)<$signed(y)}.
  - 1001–1100 and 1110: carry=0.
  - 1101: unsigned multiply; out = low WIDTH bits of x*y; carry = OR of the high WIDTH bits (overflow).
  - 1111: reserved; out=0, carry=0.
- FSM states:
  - IDLE: empty. in_ready=1.
    - Accept of a single-cycle op → FULL.
    - Accept of 1101 → MUL.
  - MUL: in_ready=0, out_valid=0.
    - Holds multiplicand, multiplier shift register, a 2·WIDTH accumulator and a down-counter loaded with WIDTH−1.
    - Each cycle: if multiplier LSB=1, add multiplicand<<i into the accumulator; shift the multiplier; decrement the counter.
    - Counter==0 in MUL → FULL, with out/carry loaded from the final accumulator.
  - FULL: out_valid=1.
    - in_ready = out_ready.
    - out_ready=0 → stay in FULL; out and carry are held stable.
    - out_ready=1 with no accept → IDLE.
    - out_ready=1 with a single-cycle op accepted → stay in FULL with the new result.
    - out_ready=1 with 1101 accepted → MUL.
- Operands are captured at accept; changes on x/y/ctrl after accept have no effect.
- in_ready is a function of state and out_ready only, never of in_valid.

## Timing
- Reset, synchronous, priority over everything:
  - state=IDLE, out_valid=0, out=0, carry=0, counter=0, accumulator=0.
  - in_ready=1 in the first cycle after rst deasserts.
- rst asserted in MUL or FULL aborts the operation; the result is discarded and never presented.
- Single-cycle op latency: accept at edge k → out_valid=1 after edge k (visible in cycle k+1).
- Multiply latency: accept at edge k → out_valid=1 after edge k+WIDTH. in_ready=0 for the WIDTH cycles from k+1 through k+WIDTH.
- Throughput:
  - Single-cycle ops sustain one result per clock while out_ready=1.
  - Multiply sustains one result per WIDTH+1 clocks.
- Backpressure: out, carry and out_valid are held unchanged for as long as out_valid && !out_ready.
- Boundaries:
  - Shift amounts use only x[SHW-1:0]; upper bits of x are ignored.
  - Multiply with either operand 0 still takes WIDTH cycles.
  - Multiply with y=1 → out=x, carry=0.
- No combinational path from in_valid, x, y or ctrl to any output.

## Test plan
- WIDTH=8, add, x=8'hFF, y=8'h01, out_ready=1:
  - carry=1, out=8'h00, one cycle after accept.
- Sub, x=8'h03, y=8'h05 → out=8'hFE, carry=1.
- NOT, x=8'h0F → out=8'hF0, carry=1.
- Shift left, y=8'hC1, x=8'h0A (amount 2) → out=8'h04, carry=1.
- Multiply, x=8'd20, y=8'd13:
  - out=8'h04, carry=1 (260).
  - out_valid rises exactly 8 cycles after accept.
  - in_ready=0 throughout.
  - Repeat with x=8'd15, y=8'd17 → out=8'hFF, carry=0.
- Back-to-back ops 0010/0011/1010/1110 with out_ready=1:
  - One result per cycle, in order.
  - 1110 with x=8'h80, y=8'h01 → out=8'h01.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result → out, carry and out_valid stable; in_ready=0.
  - Release out_ready → the next accepted result follows on the next cycle.
- Reset mid-operation:
  - Assert rst on the 4th MUL cycle → out_valid=0, out=0 after that edge.
  - in_ready=1 next cycle; no stale result ever appears.
- Repeat the add and multiply scenarios with WIDTH=16: 16'hFFFF+1 → carry=1; multiply latency = 16 cycles.
